// File: rtl/fetch_queue.sv
// Instruction prefetch queue. Each entry holds {inst, origaddr}. A pushed word reaches the head one cycle later.
// Downstream stall_i holds the head. stall_o throttles ifetch early enough to absorb in-flight imem reads.
module fetch_queue #(
  parameter int WORD       = 32,
  parameter int ADDR       = 16,
  parameter int DEPTH      = 4,
  parameter int SKID       = 2,
  parameter int FLUSH_DROP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] origaddr_i,
  output logic            stall_o,
  input  logic            flush_i,
  output logic            v_o,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] origaddr_o,
  input  logic            stall_i,
  output logic            ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (FLUSH_DROP < 1) ? 1 : $clog2(FLUSH_DROP + 1);

  logic [WORD-1:0] inst_mem_q [DEPTH];
  logic [WORD-1:0] inst_mem_d [DEPTH];
  logic [ADDR-1:0] addr_mem_q [DEPTH];
  logic [ADDR-1:0] addr_mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            ovf_q, ovf_d;

  logic accept, push, pop, ovf_evt;

  assign v_o        = (count_q != '0);
  assign stall_o    = (count_q >= CW'(DEPTH - SKID));
  assign inst_o     = v_o ? inst_mem_q[rd_ptr_q] : '0;
  assign origaddr_o = v_o ? addr_mem_q[rd_ptr_q] : '0;
  assign ovf_o      = ovf_q;

  // A word arriving while drop_cnt is nonzero is a wrong-path read and is never stored.
  assign accept  = v_i & (drop_cnt_q == '0) & ~flush_i;
  assign pop     = v_o & ~stall_i;
  assign push    = accept & ((count_q < CW'(DEPTH)) | pop);
  assign ovf_evt = accept & (count_q == CW'(DEPTH)) & ~pop;

  always_comb begin
    inst_mem_d = inst_mem_q;
    addr_mem_d = addr_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q | ovf_evt;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = DW'(FLUSH_DROP);
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = inst_i;
        addr_mem_d[wr_ptr_q] = origaddr_i;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    addr_mem_q <= addr_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard of expected head words is checked by a monitor on each pop.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i;
  logic [31:0] inst_i;
  logic [15:0] origaddr_i;
  logic        stall_o;
  logic        flush_i;
  logic        v_o;
  logic [31:0] inst_o;
  logic [15:0] origaddr_o;
  logic        stall_i;
  logic        ovf_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [47:0] sb[$];

  fetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .v_i        (v_i),
    .inst_i     (inst_i),
    .origaddr_i (origaddr_i),
    .stall_o    (stall_o),
    .flush_i    (flush_i),
    .v_o        (v_o),
    .inst_o     (inst_o),
    .origaddr_o (origaddr_o),
    .stall_i    (stall_i),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs; acc marks a word the queue is expected to store and later emit.
  task automatic cyc(input logic v, input logic [31:0] w, input logic [15:0] a,
                     input logic fl, input logic st, input logic acc);
    v_i = v; inst_i = w; origaddr_i = a; flush_i = fl; stall_i = st;
    if (acc) sb.push_back({w, a});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic st);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 16'h0, 1'b0, st, 1'b0);
  endtask

  // Monitor: compares the head against the scoreboard on every cycle a pop occurs.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (rst || flush_i) begin
        sb.delete();
      end else if (v_o && !stall_i) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL pop_unexpected: got inst 0x%0h addr 0x%0h, expected no word", inst_o, origaddr_o);
        end else begin
          e = sb.pop_front();
          if ({inst_o, origaddr_o} === e) n_pass++;
          else $display("FAIL pop_order: got inst 0x%0h addr 0x%0h, expected inst 0x%0h addr 0x%0h",
                        inst_o, origaddr_o, e[47:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; v_i = 1'b0; inst_i = '0; origaddr_i = '0; flush_i = 1'b0; stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v_o", {31'b0, v_o}, 32'd0);
    chk("rst_stall_o", {31'b0, stall_o}, 32'd0);
    chk("rst_ovf_o", {31'b0, ovf_o}, 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);
    chk("rst_addr_o", {16'b0, origaddr_o}, 32'd0);
    rst = 1'b0;

    // Basic streaming
    cyc(1'b1, 32'h11, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t1_v_o_after_push", {31'b0, v_o}, 32'd1);
    chk("t1_head", inst_o, 32'h11);
    cyc(1'b1, 32'h22, 16'h1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h33, 16'h2, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    chk("t1_empty", {31'b0, v_o}, 32'd0);

    // Downstream stall with compliant upstream
    cyc(1'b1, 32'hA1, 16'h10, 1'b0, 1'b1, 1'b1);
    chk("t2_stall_o_c1", {31'b0, stall_o}, 32'd0);
    cyc(1'b1, 32'hA2, 16'h11, 1'b0, 1'b1, 1'b1);
    chk("t2_stall_o_c2", {31'b0, stall_o}, 32'd1);
    cyc(1'b1, 32'hA3, 16'h12, 1'b0, 1'b1, 1'b1);
    chk("t2_stall_o_c3", {31'b0, stall_o}, 32'd1);
    chk("t2_head_held", inst_o, 32'hA1);
    chk("t2_ovf_o", {31'b0, ovf_o}, 32'd0);
    idle(3, 1'b0);
    chk("t2_empty", {31'b0, v_o}, 32'd0);

    // Full queue with simultaneous pop: push accepted, no overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hB0 + i, 16'h20 + 16'(i), 1'b0, 1'b1, 1'b1);
    chk("t3a_head", inst_o, 32'hB0);
    cyc(1'b1, 32'hB4, 16'h24, 1'b0, 1'b0, 1'b1);
    chk("t3a_head_next", inst_o, 32'hB1);
    chk("t3a_stall_o", {31'b0, stall_o}, 32'd1);
    chk("t3a_ovf_o", {31'b0, ovf_o}, 32'd0);
    idle(4, 1'b0);
    chk("t3a_empty", {31'b0, v_o}, 32'd0);

    // Flush at count=3 with words in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + i, 16'h30 + 16'(i), 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'hAA, 16'h40, 1'b1, 1'b1, 1'b0);
    chk("t4_v_o_after_flush", {31'b0, v_o}, 32'd0);
    cyc(1'b1, 32'hBB, 16'h41, 1'b0, 1'b0, 1'b0);
    chk("t4_v_o_drop", {31'b0, v_o}, 32'd0);
    cyc(1'b1, 32'hCC, 16'h42, 1'b0, 1'b0, 1'b1);
    chk("t4_first_word", inst_o, 32'hCC);
    chk("t4_first_addr", {16'b0, origaddr_o}, 32'h42);
    idle(1, 1'b0);

    // Flush again inside the drop window reloads it
    cyc(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hE1, 16'h50, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hE2, 16'h51, 1'b0, 1'b0, 1'b0);
    chk("t4_reload_drop", {31'b0, v_o}, 32'd0);
    cyc(1'b1, 32'hE3, 16'h52, 1'b0, 1'b0, 1'b1);
    chk("t4_reload_word", inst_o, 32'hE3);
    idle(1, 1'b0);

    // Steady push/pop at count=2, wrapping the pointers several times
    cyc(1'b1, 32'hD000_0000, 16'h100, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'hD000_0001, 16'h101, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'hD000_0002 + i, 16'h102 + 16'(i), 1'b0, 1'b0, 1'b1);
      chk("t5_head", inst_o, 32'hD000_0001 + i);
      chk("t5_stall_o", {31'b0, stall_o}, 32'd1);
    end
    idle(2, 1'b0);
    chk("t5_empty", {31'b0, v_o}, 32'd0);
    chk("t5_sb_drained", sb.size(), 32'd0);

    // Overflow: fifth push into a full, stalled queue
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hF0 + i, 16'h60 + 16'(i), 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'hF4, 16'h64, 1'b0, 1'b1, 1'b0);
    chk("t3b_ovf_o", {31'b0, ovf_o}, 32'd1);
    chk("t3b_head", inst_o, 32'hF0);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t3b_ovf_sticky", {31'b0, ovf_o}, 32'd1);
    chk("t3b_head_after_pop", inst_o, 32'hF1);

    // Reset mid-operation with count=3 and ovf_o set
    rst = 1'b1;
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("t6_v_o", {31'b0, v_o}, 32'd0);
    chk("t6_stall_o", {31'b0, stall_o}, 32'd0);
    chk("t6_ovf_o", {31'b0, ovf_o}, 32'd0);
    chk("t6_inst_o", inst_o, 32'd0);
    rst = 1'b0;
    idle(2, 1'b0);
    chk("t6_still_empty", {31'b0, v_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
